// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped data cache.
//   - Line geometry: 256-bit lines of eight 32-bit words, 5-bit byte offset.
//   - Controller state encoding (IDLE/WB/FILL/RESP).
//   - Address field extraction helpers. They work on a 64-bit zero-extended
//     address, and callers size-cast the result to the field width they need.
package dcache_pkg;

  localparam int LINE_W         = 256;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_W       = 5;
  localparam int WORD_SEL_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w);
    return addr >> (OFFSET_W + idx_w);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w);
    return (addr >> OFFSET_W) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [63:0] addr);
    return WORD_SEL_W'(addr >> 2);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/dirty/tag/data storage for LINES cache lines.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset (valid/dirty only)
//   idx                        line index shared by the read and write ports
//   rd_valid/rd_dirty/rd_tag/rd_data  combinational read of line idx
//   fill_en, fill_tag, fill_data      whole-line fill: sets valid, clears dirty
//   merge_en, merge_word, merge_data, merge_mask  byte-masked word write
//   dirty_set                  marks line idx dirty
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_W-1:0]     fill_data,
  input  logic                  merge_en,
  input  logic [WORD_SEL_W-1:0] merge_word,
  input  logic [31:0]           merge_data,
  input  logic [3:0]            merge_mask,
  input  logic                  dirty_set
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINE_W-1:0] data_d [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

  // Fill is applied before the merge so a fill and store in one cycle would
  // leave the store on top; the controller never does both, but order is safe.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = fill_tag;
      data_d[idx]  = fill_data;
    end
    if (merge_en) begin
      for (int b = 0; b < 4; b++) begin
        if (merge_mask[b]) begin
          data_d[idx][int'({merge_word, 5'b00000}) + 8*b +: 8] = merge_data[8*b +: 8];
        end
      end
    end
    if (dirty_set) begin
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   cpu_req/we/addr/wdata/mask  core request, held until cpu_ready
//   cpu_rdata, cpu_ready  load data and one-cycle completion pulse
//   mem_read_op, mem_write_op  RAM line read / write strobes
//   mem_addr, mem_wdata, mem_rdata  line address and 256-bit line data
//   hit_cnt, miss_cnt     saturating access counters (only with DCACHE_STATS_EN)
// Optional feature macro: DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_mask,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_read_op,
  output logic              mem_write_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_e state_q, state_d;

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_W-1:0]     rd_data;
  logic [31:0]           merged_word;
  logic                  hit;
  logic                  fill_en, merge_en, dirty_set;

  assign req_tag  = TAG_W'(addr_tag(64'(cpu_addr), IDX_W));
  assign req_idx  = IDX_W'(addr_index(64'(cpu_addr), IDX_W));
  assign req_word = addr_word(64'(cpu_addr));
  assign hit      = rd_valid && (rd_tag == req_tag);

  dcache_line_store #(
    .LINES(LINES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_store (
    .clk       (CLK),
    .rst_n     (RST_N),
    .idx       (req_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_data (mem_rdata),
    .merge_en  (merge_en),
    .merge_word(req_word),
    .merge_data(cpu_wdata),
    .merge_mask(cpu_mask),
    .dirty_set (dirty_set)
  );

  // Load data reflects this access's own store merge.
  always_comb begin
    merged_word = rd_data[{req_word, 5'b00000} +: 32];
    for (int b = 0; b < 4; b++) begin
      if (cpu_we && cpu_mask[b]) begin
        merged_word[8*b +: 8] = cpu_wdata[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    mem_read_op  = 1'b0;
    mem_write_op = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_en      = 1'b0;
    merge_en     = 1'b0;
    dirty_set    = 1'b0;
`ifdef DCACHE_STATS_EN
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            state_d = RESP;
          end else if (rd_valid && rd_dirty) begin
            state_d = WB;
          end else begin
            state_d = FILL;
          end
`ifdef DCACHE_STATS_EN
          hit_evt  = hit;
          miss_evt = !hit;
`endif
        end
      end
      WB: begin
        mem_write_op = 1'b1;
        mem_addr     = {rd_tag, req_idx, {OFFSET_W{1'b0}}};
        mem_wdata    = rd_data;
        state_d      = FILL;
      end
      FILL: begin
        mem_read_op = 1'b1;
        mem_addr    = {req_tag, req_idx, {OFFSET_W{1'b0}}};
        fill_en     = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = merged_word;
        merge_en  = cpu_we;
        dirty_set = cpu_we && (cpu_mask != 4'b0000);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts at once: strobes are suppressed in the reset cycle itself so
    // an in-flight writeback never reaches the RAM, and nothing is written back
    // into the line store.
    if (!RST_N) begin
      cpu_ready    = 1'b0;
      cpu_rdata    = '0;
      mem_read_op  = 1'b0;
      mem_write_op = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      fill_en      = 1'b0;
      merge_en     = 1'b0;
      dirty_set    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DCACHE_STATS_EN
  always_comb begin
    hit_cnt_d  = hit_evt  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
    miss_cnt_d = miss_evt ? sat_inc(miss_cnt_q) : miss_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the core's load/store unit and the 256-bit-line data RAM.
- Serves 32-bit word accesses with byte masks.
- Issues whole-line (8 words, 32 B) fills and writebacks to the RAM.
- The RAM reads combinationally while its read strobe is high, and writes on the CLK edge while its write strobe is high.

Parameters:
- LINES, 16: number of cache lines; power of two. IDX_W = log2(LINES).
- ADDR_W, 32: byte-address width.

Ports:
- CLK  input  1: clock.
- RST_N  input  1: reset; synchronous, active-low.
- cpu_req  input  1: access request. Held, with all cpu_* inputs stable, until cpu_ready.
- cpu_we  input  1: 1 = store, 0 = load.
- cpu_addr  input  ADDR_W: byte address. Bits [1:0] are ignored.
- cpu_wdata  input  32: store data.
- cpu_mask  input  4: store byte enables; bit i covers byte i.
- cpu_rdata  output  32: load data. Valid while cpu_ready = 1.
- cpu_ready  output  1: one-cycle completion pulse.
- mem_read_op  output  1: RAM line read strobe.
- mem_write_op  output  1: RAM line write strobe.
- mem_addr  output  ADDR_W: line-aligned byte address; bits [4:0] = 0.
- mem_wdata  output  256: line to RAM. Word k is at bits [32k+31:32k].
- mem_rdata  input  256: line from RAM; same word layout.

Behaviour:
- Address fields:
  - word = addr[4:2]
  - index = addr[5+IDX_W-1:5]
  - tag = addr[ADDR_W-1:5+IDX_W]
- Per-line state: valid bit, dirty bit, tag, 256-bit data.
- Reset (RST_N = 0 at a CLK edge):
  - All valid and dirty bits cleared.
  - State = IDLE.
  - cpu_ready, cpu_rdata, mem_read_op, mem_write_op, mem_addr and mem_wdata all forced to 0.
  - Reset asserted mid-operation aborts immediately. A pending writeback is dropped, and no strobe is issued in the cycle after reset.
- IDLE:
  - With cpu_req = 1, look up the index.
  - Hit (valid and tag match) -> RESP.
  - Miss on a clean or invalid line -> FILL.
  - Miss on a valid dirty line -> WB.
- WB (1 cycle):
  - mem_write_op = 1.
  - mem_addr = {victim tag, index, 5'b0}.
  - mem_wdata = victim line.
  - Next state FILL.
- FILL (1 cycle):
  - mem_read_op = 1.
  - mem_addr = {req tag, index, 5'b0}.
  - mem_rdata is captured into the line at the CLK edge.
  - The line's valid bit is set, dirty is cleared and the tag is updated.
  - Next state RESP.
- RESP (1 cycle):
  - cpu_ready = 1.
  - cpu_rdata = the addressed word, taken after any store merge from this access.
  - If cpu_we = 1, merge cpu_wdata under cpu_mask into the word at the CLK edge.
  - If cpu_mask != 0, set dirty. A store with mask 0 behaves as a load.
  - Next state IDLE.
- Latency, counted from the cycle cpu_req is first sampled in IDLE to the cpu_ready cycle:
  - Hit: 1.
  - Clean miss: 2.
  - Dirty miss: 3.
- Throughput: a new request is accepted in the IDLE cycle after RESP. Back-to-back hits therefore complete every 2 cycles.
- Strobes:
  - mem_read_op and mem_write_op are never high in the same cycle.
  - Both are low outside FILL and WB. mem_addr and mem_wdata are 0 outside those states.
- Same index, different tag, consecutively: each access evicts the other's line. There is no replacement policy beyond direct mapping.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs hit_cnt (32) and miss_cnt (32).
  - hit_cnt increments on the IDLE->RESP transition.
  - miss_cnt increments on IDLE->FILL and IDLE->WB.
  - Both counters saturate at 32'hFFFFFFFF and are cleared by reset.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package dcache_pkg:
  - LINE_W = 256, WORDS_PER_LINE = 8, OFFSET_W = 5.
  - State encoding IDLE/WB/FILL/RESP.
  - Functions for tag, index and word extraction.
- Sub-module dcache_line_store holds valid, dirty, tag and data for LINES entries.
  - Combinational read port by index.
  - One write port with per-field enables: line fill, byte-masked word merge, dirty set.
- The FSM and RAM-strobe logic live in dcache_ctrl.

Test Plan:
- Reset, then load 0x0000_0104 with the RAM line at 0x100 word1 = 0xDEADBEEF -> FILL at mem_addr 0x100; cpu_ready 2 cycles after req; cpu_rdata = 0xDEADBEEF.
- Repeat the same load -> hit; cpu_ready 1 cycle after req; no mem strobe.
- Store 0x11223344 mask 4'b0101 to 0x104, then load 0x104 -> cpu_rdata = 0xDE22BE44; line dirty.
- Load 0x0000_0304 (same index 8, LINES = 16, different tag) -> WB at mem_addr 0x100 with word1 = 0xDE22BE44, then FILL at 0x300; cpu_ready 3 cycles after req.
- Reset asserted during the WB cycle -> strobes 0 next cycle; re-access of 0x104 misses clean (FILL only).
- DCACHE_STATS_EN defined, sequence miss, hit, hit, miss -> hit_cnt = 2, miss_cnt = 2.
